// File: rtl/div_clk_monitor_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package div_clk_monitor_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  localparam int TOL_DEF      = 1;
  localparam int LOCK_CNT_DEF = 4;
endpackage

// File: rtl/div_clk_monitor_sync_edge.sv
// sync_edge: 2-flop synchronizer, history flop and registered rising-edge strobe
// for any asynchronous level input.
module div_clk_monitor_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o,
  output logic tick_o
);
  logic s1_q, s2_q, s3_q, tick_q;

  assign edge_o = s2_q & ~s3_q;
  assign tick_o = tick_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      tick_q <= edge_o;
    end
  end
endmodule

// File: rtl/div_clk_monitor.sv
// Turns the divided clock into a clock-enable strobe and checks its period
// against the programmed divisor, reporting lock, error pulses and a sticky fault.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int WIDE     = 32,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [WIDE-1:0] iDIV,
  input  logic            iDIVCLK,
  output logic            oTICK,
  output logic [WIDE-1:0] oPERIOD,
  output logic            oLOCK,
  output logic            oERR,
  output logic            oFAULT
);
  localparam int MW = $clog2(LOCK_CNT + 1);

  state_e          state_q;
  logic [WIDE-1:0] div_q, cnt_q, period_q, period_d;
  logic [MW-1:0]   mcnt_q, mcnt_d;
  logic            to_q, lock_q, err_q, fault_q;
  logic            edg, chg, bypass, match, cnt_gt, tmo;
  logic [WIDE:0]   pdiff;

  div_clk_monitor_sync_edge u_sync (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .async_i(iDIVCLK),
    .edge_o (edg),
    .tick_o (oTICK)
  );

  always_comb begin
    period_d = (&cnt_q) ? cnt_q : cnt_q + WIDE'(1);
    pdiff    = (period_d >= div_q) ? {1'b0, period_d} - {1'b0, div_q}
                                   : {1'b0, div_q} - {1'b0, period_d};
    match    = pdiff <= (WIDE+1)'(TOL);
    // Limit is 2*div+TOL, held one bit wider so large divisors cannot wrap.
    cnt_gt   = {2'b00, cnt_q} > ({1'b0, div_q, 1'b0} + (WIDE+2)'(TOL));
    tmo      = cnt_gt & ~to_q & ~edg;
    chg      = iDIV != div_q;
    bypass   = iDIV < WIDE'(2);
    mcnt_d   = mcnt_q + MW'(1);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q  <= ST_SYNC;
      div_q    <= '0;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      to_q     <= 1'b0;
      period_q <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      div_q <= iDIV;
      if (chg || edg)  cnt_q <= '0;
      else if (~&cnt_q) cnt_q <= cnt_q + WIDE'(1);
      // Timeout fires once per silent stretch; the counter keeps saturating.
      to_q <= (chg || edg) ? 1'b0 : (to_q | cnt_gt);
      if (chg) fault_q <= 1'b0;

      if (bypass) begin
        state_q <= ST_IDLE;
        lock_q  <= 1'b0;
        mcnt_q  <= '0;
      end else if (chg) begin
        state_q <= ST_SYNC;
        lock_q  <= 1'b0;
        mcnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_SYNC;
          ST_SYNC: if (edg) state_q <= ST_ACQUIRE;
          ST_ACQUIRE: begin
            if (edg) begin
              period_q <= period_d;
              if (!match) begin
                mcnt_q <= '0;
              end else if (mcnt_d == MW'(LOCK_CNT)) begin
                state_q <= ST_LOCKED;
                lock_q  <= 1'b1;
                mcnt_q  <= '0;
              end else begin
                mcnt_q <= mcnt_d;
              end
            end else if (tmo) begin
              mcnt_q <= '0;
            end
          end
          ST_LOCKED: begin
            if (edg) period_q <= period_d;
            if ((edg && !match) || tmo) begin
              err_q   <= 1'b1;
              fault_q <= 1'b1;
              lock_q  <= 1'b0;
              mcnt_q  <= '0;
              state_q <= ST_ACQUIRE;
            end
          end
          default: state_q <= ST_SYNC;
        endcase
      end
    end
  end

  assign oPERIOD = period_q;
  assign oLOCK   = lock_q;
  assign oERR    = err_q;
  assign oFAULT  = fault_q;
endmodule
